// File: rtl/addsub_digit_serial_if.sv
// rtl/addsub_digit_serial_if.sv - start/busy/done operand and result bundle for addsub_digit_serial
interface addsub_digit_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             Sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Overflow;

   modport master (
      output start, Sub, A, B, Cin,
      input  busy, done, Sum, Cout, Overflow
   );

   modport slave (
      input  start, Sub, A, B, Cin,
      output busy, done, Sum, Cout, Overflow
   );
endinterface

// File: rtl/addsub_digit_serial.sv
// rtl/addsub_digit_serial.sv - digit-serial add/subtract through one shared DIGIT-bit ripple slice; ADDSUB_SAT_EN enables result saturation
module addsub_digit_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                  clk,
   input logic                  reset,
   addsub_digit_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("addsub_digit_serial: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             load;
   logic             last;

   // operands are shifted right one digit per RUN edge so the slice always sees bit 0
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shadow_q;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             c_top;
   logic [WIDTH-1:0] res_full;
   logic [WIDTH-1:0] res_out;

`ifdef ADDSUB_SAT_EN
   logic             a_sign_q;
`endif

   assign last = (state_q == S_RUN) && (cnt_q == CW'(N - 1));

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and load decode; start is only honoured outside RUN
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy     = (state_q == S_RUN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.Sum      = sum_q;
   assign bus.Cout     = cout_q;
   assign bus.Overflow = ovf_q;

   // shared ripple slice; c_top is the carry into the slice MSB, i.e. into bit WIDTH-1 on the last digit
   always_comb begin
      logic [DIGIT:0]       c;
      logic [WIDTH+DIGIT-1:0] cat;
      c[0] = carry_q;
      for (int i = 0; i < DIGIT; i++) begin
         slice_sum[i] = a_q[i] ^ b_q[i] ^ c[i];
         c[i+1]       = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
      end
      slice_cout = c[DIGIT];
      c_top      = c[DIGIT-1];
      // new digit enters at the top; after N digits the first digit has reached bit 0
      cat        = {slice_sum, shadow_q} >> DIGIT;
      res_full   = cat[WIDTH-1:0];
   end

   // final result selection: wrapped, or clamped on signed overflow when saturation is built in
   always_comb begin
      res_out = res_full;
`ifdef ADDSUB_SAT_EN
      if (c_top ^ slice_cout) begin
         res_out = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // operand capture, per-digit datapath and result/flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         shadow_q <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ADDSUB_SAT_EN
         a_sign_q <= 1'b0;
`endif
      end else if (load) begin
         a_q      <= bus.A;
         b_q      <= bus.Sub ? ~bus.B : bus.B;
         carry_q  <= bus.Cin ^ bus.Sub;
         cnt_q    <= '0;
         shadow_q <= '0;
`ifdef ADDSUB_SAT_EN
         a_sign_q <= bus.A[WIDTH-1];
`endif
      end else if (state_q == S_RUN) begin
         a_q      <= a_q >> DIGIT;
         b_q      <= b_q >> DIGIT;
         carry_q  <= slice_cout;
         cnt_q    <= cnt_q + CW'(1);
         shadow_q <= res_full;
         if (last) begin
            sum_q  <= res_out;
            cout_q <= slice_cout;
            ovf_q  <= c_top ^ slice_cout;
         end
      end
   end
endmodule

// File: tb/tb_addsub_digit_serial.sv
// tb/tb_addsub_digit_serial.sv - scoreboard bench for addsub_digit_serial with randomized operands
module tb_addsub_digit_serial;
   localparam int W = 16;
   localparam int D = 4;
   localparam int N = W / D;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   addsub_digit_serial_if #(.WIDTH(W)) bus ();

   addsub_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] sum;
      logic        co;
      logic        ov;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [15:0] held_sum = '0;
   logic        held_co = 1'b0;
   logic        held_ov = 1'b0;

   // count of rising edges seen so far
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // reference: signed/unsigned integer arithmetic on whole operands
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic cin, input int dcyc);
      exp_t e;
      int   sa, sbv, sr, ua, ub, ur;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      ua  = int'(a);
      ub  = int'(b);
      if (sub) begin
         sr   = sa - sbv - int'(cin);
         ur   = ua - ub - int'(cin);
         e.co = (ur >= 0);
      end else begin
         sr   = sa + sbv + int'(cin);
         ur   = ua + ub + int'(cin);
         e.co = (ur > 65535);
      end
      e.sum = ur[15:0];
      e.ov  = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
      if (e.ov) e.sum = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
      e.cyc = dcyc;
      return e;
   endfunction

   // monitor: pop an expectation on every done, otherwise verify outputs hold
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !reset) begin
         if (bus.done) begin
            chk("busy_in_done", 32'(bus.busy), 32'd0);
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("sum", 32'(bus.Sum), 32'(e.sum));
               chk("cout", 32'(bus.Cout), 32'(e.co));
               chk("overflow", 32'(bus.Overflow), 32'(e.ov));
               held_sum = e.sum;
               held_co  = e.co;
               held_ov  = e.ov;
            end
         end else begin
            chk("result_hold", {14'd0, bus.Cout, bus.Overflow, bus.Sum}, {14'd0, held_co, held_ov, held_sum});
            if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
               chk("done_missing", 32'd0, 32'd1);
               e = sbq.pop_front();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
      int g;
      g = 0;
      while (bus.busy && g < 50) begin
         tick();
         g++;
      end
      if (bus.busy) chk("busy_timeout", 32'd1, 32'd0);
      bus.A     = a;
      bus.B     = b;
      bus.Sub   = sub;
      bus.Cin   = cin;
      bus.start = 1'b1;
      sbq.push_back(model(a, b, sub, cin, cyc + 1 + N));
      tick();
      bus.start = 1'b0;
   endtask

   task automatic finish_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      n_fail++;
      finish_run();
   end

   initial begin
      logic [15:0] corners [6];
      logic [15:0] ra, rb;
      int          a0;
      corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};

      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Sub   = 1'b0;
      bus.Cin   = 1'b0;
      reset     = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_sum", 32'(bus.Sum), 32'd0);
      chk("rst_flags", {30'd0, bus.Cout, bus.Overflow}, 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // plain add, with start pulses while busy that must be ignored
      issue(16'h1234, 16'h0FF0, 1'b0, 1'b0);
      bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.Sub = 1'b1; bus.Cin = 1'b1;
      bus.start = 1'b1;
      tick();
      tick();
      bus.start = 1'b0;

      // signed overflow on add, then carry-out without overflow
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'hFFFF, 16'h0000, 1'b0, 1'b1);

      // subtraction cases
      issue(16'h0005, 16'h0007, 1'b1, 1'b0);
      issue(16'h8000, 16'h0001, 1'b1, 1'b0);

      // reset two edges into RUN aborts the operation and clears results
      while (bus.busy) tick();
      bus.A = 16'h4321; bus.B = 16'h1111; bus.Sub = 1'b0; bus.Cin = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_sum", 32'(bus.Sum), 32'd0);
      held_sum = '0;
      held_co  = 1'b0;
      held_ov  = 1'b0;
      reset    = 1'b0;
      repeat (8) tick();
      issue(16'h00FF, 16'h0101, 1'b0, 1'b0);

      // back-to-back: start held high across DONE with new operands
      a0 = 0;
      while (bus.busy) tick();
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      a0 = cyc;
      tick();
      tick();
      bus.A = 16'h0001; bus.B = 16'h0001; bus.Sub = 1'b0; bus.Cin = 1'b0;
      bus.start = 1'b1;
      sbq.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0, a0 + N + 1 + N));
      repeat (3) tick();
      bus.start = 1'b0;

      // randomized operands with random idle gaps, biased toward sign/carry corners
      for (int k = 0; k < 150; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         repeat ($urandom_range(0, 2)) tick();
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      for (int k = 0; k < 30 && sbq.size() > 0; k++) tick();
      tick();
      chk("scoreboard_drained", sbq.size(), 32'd0);
      finish_run();
   end
endmodule

// File: doc/addsub_digit_serial.md
Name: addsub_digit_serial

Overview:
- Parametrised, multi-cycle adder/subtractor; next generation of the team's single-bit full-adder cell.
- Computes A+B or A−B on WIDTH-bit operands, DIGIT bits per clock, through one shared DIGIT-bit ripple slice.
- Start/busy/done handshake; Cout and signed Overflow flags.
- Used where area matters more than latency, e.g. shared arithmetic in sequencers and accumulators.

Parameters:
WIDTH, 16, operand/result width in bits; ≥ 2.
DIGIT, 4, bits processed per clock; must divide WIDTH exactly (elaboration-time error otherwise). N = WIDTH/DIGIT.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
Sub  input  1  0 = add, 1 = subtract; captured with operands
A  input  WIDTH  operand A; captured on accepted start
B  input  WIDTH  operand B; captured on accepted start
Cin  input  1  carry-in (add) / borrow-in (sub); captured on accepted start
busy  output  1  high while operation in progress
done  output  1  one-cycle pulse: result valid
Sum  output  WIDTH  result; holds until next done
Cout  output  1  carry out of MSB (sub: 1 = no borrow)
Overflow  output  1  signed overflow

Behaviour:
- Reset:
  - Reset high at an edge: state=IDLE; busy=0, done=0, Sum=0, Cout=0, Overflow=0; internal registers cleared.
  - Reset overrides start.
  - Reset mid-operation aborts; no done pulse is produced.
- States:
  - IDLE: busy=0, done=0. start=1 → load, go to RUN.
  - RUN: busy=1. One digit per edge, LSB digit first. After the N-th digit → DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 → load, go to RUN; otherwise → IDLE.
- Load (at accepted start edge t):
  - Capture A, B, and Sub.
  - Internal carry register = Cin XOR Sub.
  - Digit counter = 0.
- Arithmetic:
  - Effective B operand = Sub ? ~B : B.
  - Per RUN edge: DIGIT-bit ripple add of the current A digit, effective-B digit and carry register. Write the result digit to the shadow result. Carry register = slice carry-out.
  - At the last digit, also record c_msb_in, the carry into bit WIDTH−1.
- Latency: digits are processed at edges t+1 … t+N. At edge t+N:
  - Sum = full result.
  - Cout = final carry.
  - Overflow = c_msb_in XOR final carry.
  - done is high for the cycle after edge t+N; busy falls at the same edge.
  - Example: N=4 → done visible after edge t+4.
- Sum/Cout/Overflow change only at the done-producing edge; they hold stable through IDLE and during the next RUN.
- start while busy=1 is ignored, with no queuing. Input changes during RUN have no effect.
- Back-to-back: start held high in DONE is accepted. The new op's done follows N+1 edges after the previous done edge.
- DIGIT=WIDTH (N=1) is legal: done follows one edge after load.
- All arithmetic is modulo 2^WIDTH; no X propagation from the unused counter range. The counter wraps cleanly to 0 on load.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - When Overflow=1 at the done edge, Sum is clamped instead of wrapped.
  - Clamp to 2^(WIDTH−1)−1 if the A sign bit is 0, else to −2^(WIDTH−1).
  - Overflow and Cout still report the unsaturated flags.
- Undefined: Sum is the wrapped result; no saturation logic is present.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4; done is checked exactly 4 edges after start.
1. Reset mid-RUN (assert reset at edge t+2) → next cycle busy=0, done=0, Sum=0x0000. No done appears later. A subsequent start completes normally.
2. Add, Sub=0, Cin=0, A=0x1234, B=0x0FF0 → Sum=0x2224, Cout=0, Overflow=0. start pulsed at t+1 and t+2 while busy is ignored.
3. Add overflow, A=0x7FFF, B=0x0001, Cin=0 → Sum=0x8000, Cout=0, Overflow=1. Chained add A=0xFFFF, B=0x0000, Cin=1 → Sum=0x0000, Cout=1, Overflow=0.
4. Subtract, Sub=1, Cin=0:
   - A=0x0005, B=0x0007 → Sum=0xFFFE, Cout=0, Overflow=0.
   - A=0x8000, B=0x0001 → Sum=0x7FFF, Cout=1, Overflow=1.
5. Back-to-back: start held high across DONE with new operands A=0x0001, B=0x0001 → second done exactly 5 edges after the first. Sum=0x0002. Sum holds the first result until then.
6. With ADDSUB_SAT_EN:
   - 0x7FFF+0x0001 → Sum=0x7FFF, Overflow=1.
   - 0x8000−0x0001 → Sum=0x8000, Overflow=1.
   - Without the macro, the same cases give 0x8000 and 0x7FFF.
